// File: rtl/idx_seq_pkg.sv
// Shared state encoding and index-register control codes for the index sequencer.
package idx_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_INC,
        S_DONE
    } state_t;

    localparam logic [4:0] CS_NOP  = 5'b00000;
    localparam logic [4:0] CS_LOAD = 5'b11010;
    localparam logic [4:0] CS_INC  = 5'b11011;

endpackage

// File: rtl/idx_seq_wdog.sv
// REQ-phase watchdog: counts cycles without mem_ack and flags expiry on the
// cycle whose edge would make the count reach TIMEOUT_CYCLES.
module idx_seq_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/index_seq.sv
// Index-register block walker: LOAD base, then REQ/INC per access, DONE pulse.
// Optional REQ timeout enabled by defining IDX_SEQ_TIMEOUT_EN.
module index_seq
    import idx_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] base,
    input  logic [7:0] count,
    input  logic       mem_ack,
    output logic [4:0] cs,
    output logic [7:0] pcontrol,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state;
    logic [7:0] idx;
    logic [7:0] remaining;
    logic       expired;

`ifdef IDX_SEQ_TIMEOUT_EN
    logic wd_clear;
    logic wd_run;

    assign wd_clear = (state != S_REQ);
    assign wd_run   = (state == S_REQ) && !mem_ack;

    idx_seq_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (expired)
    );
`else
    // Parameter kept for interface compatibility; no timeout without the macro.
    assign expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // Outputs are registered alongside the state they belong to, so each
    // transition loads the Moore outputs of its destination state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            remaining <= '0;
            cs        <= CS_NOP;
            pcontrol  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cs       <= CS_NOP;
            pcontrol <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        idx       <= base;
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count != 8'd0) begin
                            state    <= S_LOAD;
                            cs       <= CS_LOAD;
                            pcontrol <= base;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= idx;
                    end
                end
                S_REQ: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (mem_ack) begin
                        if (remaining == 8'd1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_INC;
                            cs    <= CS_INC;
                        end
                    end else if (expired) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= idx;
                    end
                end
                S_INC: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx       <= idx + 8'd1;
                        remaining <= remaining - 8'd1;
                        state     <= S_REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= idx + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_index_seq.sv
// Directed self-checking bench for index_seq; each cycle compares the packed
// output bundle {cs, pcontrol, mem_req, mem_addr, busy, done, err}.
module tb_index_seq;

    localparam logic [4:0] T_NOP  = 5'b00000;
    localparam logic [4:0] T_LOAD = 5'b11010;
    localparam logic [4:0] T_INC  = 5'b11011;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] base;
    logic [7:0] count;
    logic       mem_ack;
    logic [4:0] cs;
    logic [7:0] pcontrol;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       busy;
    logic       done;
    logic       err;

    int unsigned passed;
    int unsigned total;

    index_seq #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .base     (base),
        .count    (count),
        .mem_ack  (mem_ack),
        .cs       (cs),
        .pcontrol (pcontrol),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] e(input logic [4:0] c, input logic [7:0] pc, input logic rq,
                                      input logic [7:0] a, input logic b, input logic d, input logic er);
        return {c, pc, rq, a, b, d, er};
    endfunction

    function automatic logic [24:0] snap();
        return {cs, pcontrol, mem_req, mem_addr, busy, done, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] b, input logic [7:0] c);
        base  = b;
        count = c;
        start = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        total++;
        if (snap() !== 25'd0) $display("FAIL reset_held: got %h want %h", snap(), 25'd0);
        else passed++;
        reset = 1'b0;
        tick();
        total++;
        if (snap() !== 25'd0) $display("FAIL reset_idle: got %h want %h", snap(), 25'd0);
        else passed++;
    endtask

    task automatic test_basic_walk();
        logic [24:0] exp [8];
        exp[0] = e(T_LOAD, 8'h10, 0, 8'h00, 1, 0, 0);
        exp[1] = e(T_NOP,  8'h00, 1, 8'h10, 1, 0, 0);
        exp[2] = e(T_INC,  8'h00, 0, 8'h00, 1, 0, 0);
        exp[3] = e(T_NOP,  8'h00, 1, 8'h11, 1, 0, 0);
        exp[4] = e(T_INC,  8'h00, 0, 8'h00, 1, 0, 0);
        exp[5] = e(T_NOP,  8'h00, 1, 8'h12, 1, 0, 0);
        exp[6] = e(T_NOP,  8'h00, 0, 8'h00, 1, 1, 0);
        exp[7] = e(T_NOP,  8'h00, 0, 8'h00, 0, 0, 0);
        mem_ack = 1'b1;
        launch(8'h10, 8'd3);
        for (int k = 0; k < 8; k++) begin
            tick();
            start = 1'b0;
            total++;
            if (snap() !== exp[k]) $display("FAIL basic_walk cyc%0d: got %h want %h", k + 1, snap(), exp[k]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [24:0] exp [9];
        exp[0] = e(T_LOAD, 8'hFE, 0, 8'h00, 1, 0, 0);
        exp[1] = e(T_NOP,  8'h00, 1, 8'hFE, 1, 0, 0);
        exp[2] = e(T_INC,  8'h00, 0, 8'h00, 1, 0, 0);
        exp[3] = e(T_NOP,  8'h00, 1, 8'hFF, 1, 0, 0);
        exp[4] = e(T_INC,  8'h00, 0, 8'h00, 1, 0, 0);
        exp[5] = e(T_NOP,  8'h00, 1, 8'h00, 1, 0, 0);
        exp[6] = e(T_NOP,  8'h00, 0, 8'h00, 1, 1, 0);
        exp[7] = e(T_NOP,  8'h00, 0, 8'h00, 0, 0, 0);
        exp[8] = e(T_NOP,  8'h00, 0, 8'h00, 0, 0, 0);
        mem_ack = 1'b1;
        launch(8'hFE, 8'd3);
        for (int k = 0; k < 9; k++) begin
            tick();
            start = 1'b0;
            total++;
            if (snap() !== exp[k]) $display("FAIL wrap cyc%0d: got %h want %h", k + 1, snap(), exp[k]);
            else passed++;
        end
    endtask

    task automatic test_zero_count();
        logic [24:0] exp [3];
        exp[0] = e(T_NOP, 8'h00, 0, 8'h00, 1, 1, 0);
        exp[1] = e(T_NOP, 8'h00, 0, 8'h00, 0, 0, 0);
        exp[2] = e(T_NOP, 8'h00, 0, 8'h00, 0, 0, 0);
        mem_ack = 1'b1;
        launch(8'h55, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            start = 1'b0;
            total++;
            if (snap() !== exp[k]) $display("FAIL zero_count cyc%0d: got %h want %h", k + 1, snap(), exp[k]);
            else passed++;
        end
    endtask

    task automatic test_delayed_ack();
        logic [24:0] exp [13];
        exp[0] = e(T_LOAD, 8'h20, 0, 8'h00, 1, 0, 0);
        exp[1] = e(T_NOP,  8'h00, 1, 8'h20, 1, 0, 0);
        exp[2] = e(T_INC,  8'h00, 0, 8'h00, 1, 0, 0);
        for (int k = 3; k < 9; k++) exp[k] = e(T_NOP, 8'h00, 1, 8'h21, 1, 0, 0);
        exp[9]  = e(T_INC, 8'h00, 0, 8'h00, 1, 0, 0);
        exp[10] = e(T_NOP, 8'h00, 1, 8'h22, 1, 0, 0);
        exp[11] = e(T_NOP, 8'h00, 0, 8'h00, 1, 1, 0);
        exp[12] = e(T_NOP, 8'h00, 0, 8'h00, 0, 0, 0);
        mem_ack = 1'b1;
        launch(8'h20, 8'd3);
        for (int k = 1; k <= 13; k++) begin
            tick();
            total++;
            if (snap() !== exp[k-1]) $display("FAIL delayed_ack cyc%0d: got %h want %h", k, snap(), exp[k-1]);
            else passed++;
            mem_ack = !(k >= 3 && k <= 8);
            if (k == 3) begin
                launch(8'h77, 8'd9);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_abort_ack();
        logic [24:0] exp [5];
        exp[0] = e(T_LOAD, 8'h30, 0, 8'h00, 1, 0, 0);
        exp[1] = e(T_NOP,  8'h00, 1, 8'h30, 1, 0, 0);
        exp[2] = e(T_NOP,  8'h00, 0, 8'h00, 0, 0, 0);
        exp[3] = e(T_NOP,  8'h00, 0, 8'h00, 0, 0, 0);
        exp[4] = e(T_NOP,  8'h00, 0, 8'h00, 0, 0, 0);
        mem_ack = 1'b1;
        launch(8'h30, 8'd3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            start = 1'b0;
            total++;
            if (snap() !== exp[k-1]) $display("FAIL abort_ack cyc%0d: got %h want %h", k, snap(), exp[k-1]);
            else passed++;
            abort = (k == 2);
        end
    endtask

    task automatic test_reset_mid_walk();
        logic [24:0] exp [3];
        exp[0] = e(T_LOAD, 8'h40, 0, 8'h00, 1, 0, 0);
        exp[1] = e(T_NOP,  8'h00, 1, 8'h40, 1, 0, 0);
        exp[2] = e(T_INC,  8'h00, 0, 8'h00, 1, 0, 0);
        mem_ack = 1'b1;
        launch(8'h40, 8'd3);
        for (int k = 1; k <= 3; k++) begin
            tick();
            start = 1'b0;
            total++;
            if (snap() !== exp[k-1]) $display("FAIL reset_mid cyc%0d: got %h want %h", k, snap(), exp[k-1]);
            else passed++;
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (snap() !== 25'd0) $display("FAIL reset_mid_async: got %h want %h", snap(), 25'd0);
        else passed++;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (snap() !== 25'd0) $display("FAIL reset_mid_after cyc%0d: got %h want %h", k, snap(), 25'd0);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        logic [24:0] want;
        mem_ack = 1'b0;
        launch(8'h50, 8'd2);
        for (int k = 1; k <= 19; k++) begin
            tick();
            start = 1'b0;
            if (k == 1) begin
                want = e(T_LOAD, 8'h50, 0, 8'h00, 1, 0, 0);
            end else begin
`ifdef IDX_SEQ_TIMEOUT_EN
                if (k <= 17)       want = e(T_NOP, 8'h00, 1, 8'h50, 1, 0, 0);
                else if (k == 18)  want = e(T_NOP, 8'h00, 0, 8'h00, 1, 1, 1);
                else               want = e(T_NOP, 8'h00, 0, 8'h00, 0, 0, 0);
`else
                want = e(T_NOP, 8'h00, 1, 8'h50, 1, 0, 0);
`endif
            end
            total++;
            if (snap() !== want) $display("FAIL timeout cyc%0d: got %h want %h", k, snap(), want);
            else passed++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (snap() !== 25'd0) $display("FAIL timeout_end: got %h want %h", snap(), 25'd0);
        else passed++;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        base    = '0;
        count   = '0;
        mem_ack = 1'b0;
        test_reset();
        test_basic_walk();
        test_wrap();
        test_zero_count();
        test_delayed_ack();
        test_abort_ack();
        test_reset_mid_walk();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got %0d checks, want completion", total);
        $fatal(1, "time limit");
    end

endmodule
